timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//  - Memory-mapped programmable down-counter that generates the external interrupt consumed by the mips core.
//  - Sits on the bridge side of the CPU; its irq output drives the core's interrupt input.
//  - Three word registers: CTRL, PRESET, COUNT.
//  - Two modes: one-shot with sticky irq, and auto-reload with a one-cycle irq pulse.
// PARAMETERS
//  CNT_W       32  width of PRESET/COUNT (<=32; rdata zero-extended)
//  PRESCALE_W   8  width of prescaler register (used only with TC_PRESCALE_EN)
// PORTS
//  clk     in   1      system clock, all state on rising edge
//  reset   in   1      asynchronous, active-low; clears all state immediately
//  we      in   1      write strobe, sampled on rising clk
//  addr    in   2      word select: 0=CTRL 1=PRESET 2=COUNT 3=PRESCALE/reserved
//  wdata   in   32     write data
//  rdata   out  32     combinational read of register at addr
//  irq     out  1      interrupt request to core = CTRL.IM & pending
// BEHAVIOUR
//  - Reset (reset==0, async): CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE; irq=0, rdata reflects zeros.
//  - CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; [31:4] read 0.
//  - Write CTRL: updates EN/MODE/IM and clears pending (unless set in the same cycle, see below).
//  - Write PRESET: stored; takes effect only at the next LOAD. Write COUNT: ignored. Write addr 3 without macro: ignored.
//  - FSM, one transition per clk:
//    IDLE: EN=1 -> LOAD; else stay.
//    LOAD: COUNT<=PRESET; -> CNT.
//    CNT:  EN=0 -> IDLE (COUNT holds).
//          Else if tick and COUNT>1: COUNT-1.
//          Else if tick and COUNT<=1: COUNT<=0, pending<=1, -> INT.
//    INT:  MODE=01: pending<=0, -> LOAD.
//          Else: EN<=0, -> IDLE; pending stays set until a CTRL write.
//  - tick=1 every cycle (no macro).
//  - Latency: EN written at edge E0 -> LOAD at E1 -> COUNT=PRESET after E2. pending set at edge E2+N for PRESET=N>=1; PRESET=0 expires at E3.
//  - Auto-reload period = N+2 cycles; irq high exactly 1 cycle per period (when IM=1).
//  - Simultaneous CTRL write and expiry: new CTRL value taken; pending set wins over clear (no lost interrupt).
//  - Clearing EN mid-count: stop next edge, no irq. Re-enabling restarts from LOAD (fresh PRESET).
//  - Async reset mid-count: everything cleared at once; irq drops without waiting for clk.
//  - No underflow wrap: COUNT never goes below 0.
// CONFIGURATION
//  TC_PRESCALE_EN defined:
//   - addr 3 is RW PRESCALE[PRESCALE_W-1:0], reset 0.
//   - Internal divider: tick=1 once every PRESCALE+1 cycles while in CNT.
//   - Divider resets to 0 in LOAD and IDLE.
//   - Expiry latency becomes E2+N*(PRESCALE+1).
//  TC_PRESCALE_EN undefined:
//   - addr 3 reads 0, writes ignored, tick=1 always.
// TESTING
//  1 Reset: hold reset=0 mid-count -> irq=0, all reads 0 immediately; release -> IDLE.
//  2 One-shot: PRESET=5, CTRL=0x9 -> COUNT 5,4,3,2,1, irq rises 7 edges after CTRL write.
//    irq stays high, EN reads 0; CTRL write 0x8 -> irq=0 next cycle.
//  3 Auto-reload: PRESET=3, CTRL=0xB -> irq 1-cycle pulses every 5 cycles for >=4 periods.
//    IM=0 run -> irq never asserts.
//  4 Mid-op: EN cleared at COUNT=2 -> COUNT holds 2, no irq.
//    PRESET=0 with EN -> irq at edge E3. PRESET rewritten while counting -> current run unaffected.
//  5 Collision: CTRL write in the expiry cycle -> pending=1 after edge. Write COUNT=7 -> readback unchanged.
//  6 TC_PRESCALE_EN: PRESCALE=2, PRESET=4 one-shot -> expiry at E2+12; addr 3 reads back 2.
//    Without macro: addr 3 reads 0.

Source files
------------

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped programmable down-counter producing the external interrupt
//   for the CPU core. It has three word registers (CTRL, PRESET, COUNT) and
//   an optional PRESCALE register.
//
//   Modes:
//     MODE=00 (and 1x) one-shot. irq is sticky until software writes CTRL,
//                      and EN self-clears on expiry.
//     MODE=01          auto-reload. irq is a one-cycle pulse every PRESET+2 cycles.
//
//   Optional feature macro: TC_PRESCALE_EN
//     If defined, addr 3 is a read/write PRESCALE register and the count
//     advances once every PRESCALE+1 cycles.
//     If undefined, addr 3 reads 0, writes to it are dropped, and the count
//     advances every cycle.
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   we     in   1   write strobe
//   addr   in   2   0=CTRL 1=PRESET 2=COUNT 3=PRESCALE/reserved
//   wdata  in  32   write data
//   rdata  out 32   combinational read of the addressed register
//   irq    out  1   CTRL.IM & pending
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               en_r;
    logic [1:0]         mode_r;
    logic               im_r;
    logic               pending_r;
    logic [CNT_W-1:0]   preset_r;
    logic [CNT_W-1:0]   count_r;
    logic [PRESCALE_W-1:0] prescale_s;

    logic ctrl_wr_s;
    logic preset_wr_s;
    logic tick_s;
    logic auto_s;
    logic load_s;
    logic dec_s;
    logic expire_s;
    logic reload_clr_s;
    logic oneshot_done_s;

    assign ctrl_wr_s   = we && (addr == 2'd0);
    assign preset_wr_s = we && (addr == 2'd1);
    // Only 01 selects auto-reload; 1x falls back to one-shot.
    assign auto_s      = (mode_r == 2'b01);
    assign irq         = im_r & pending_r;

`ifdef TC_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_r;
    logic [PRESCALE_W-1:0] div_r;

    // >= rather than == so that shrinking PRESCALE mid-count cannot strand the divider.
    assign tick_s     = (div_r >= prescale_r);
    assign prescale_s = prescale_r;

    // Prescale register, software written through addr 3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_r <= {PRESCALE_W{1'b0}};
        end else if (we && (addr == 2'd3)) begin
            prescale_r <= wdata[PRESCALE_W-1:0];
        end
    end

    // Cycle divider. It runs only while counting and restarts from 0 in every other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_r <= {PRESCALE_W{1'b0}};
        end else if (state_r != ST_CNT) begin
            div_r <= {PRESCALE_W{1'b0}};
        end else if (tick_s) begin
            div_r <= {PRESCALE_W{1'b0}};
        end else begin
            div_r <= div_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign tick_s     = 1'b1;
    assign prescale_s = {PRESCALE_W{1'b0}};
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_nx_s     = state_r;
        load_s         = 1'b0;
        dec_s          = 1'b0;
        expire_s       = 1'b0;
        reload_clr_s   = 1'b0;
        oneshot_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en_r) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s     = 1'b1;
                state_nx_s = ST_CNT;
            end
            ST_CNT: begin
                if (!en_r) begin
                    state_nx_s = ST_IDLE;
                end else if (!tick_s) begin
                    state_nx_s = ST_CNT;
                end else if (count_r > CNT_W'(1)) begin
                    dec_s = 1'b1;
                end else begin
                    // A COUNT of 0 or 1 expires without wrapping.
                    expire_s   = 1'b1;
                    state_nx_s = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_s) begin
                    reload_clr_s = 1'b1;
                    state_nx_s   = ST_LOAD;
                end else begin
                    oneshot_done_s = 1'b1;
                    state_nx_s     = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // CTRL register. A software write takes precedence over the one-shot EN self-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r   <= 1'b0;
            mode_r <= 2'b00;
            im_r   <= 1'b0;
        end else if (ctrl_wr_s) begin
            en_r   <= wdata[0];
            mode_r <= wdata[2:1];
            im_r   <= wdata[3];
        end else if (oneshot_done_s) begin
            en_r <= 1'b0;
        end
    end

    // Pending flag. An expiry in the same cycle as a CTRL write must not be lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= 1'b0;
        end else if (expire_s) begin
            pending_r <= 1'b1;
        end else if (ctrl_wr_s || reload_clr_s) begin
            pending_r <= 1'b0;
        end
    end

    // PRESET register. The new value is picked up at the next LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset_r <= {CNT_W{1'b0}};
        end else if (preset_wr_s) begin
            preset_r <= wdata[CNT_W-1:0];
        end
    end

    // COUNT register. It is not writable by software.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            count_r <= preset_r;
        end else if (dec_s) begin
            count_r <= count_r - CNT_W'(1);
        end else if (expire_s) begin
            count_r <= {CNT_W{1'b0}};
        end
    end

    // Read mux with zero extension.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, im_r, mode_r, en_r};
            2'd1:    rdata = 32'(preset_r);
            2'd2:    rdata = 32'(count_r);
            2'd3:    rdata = 32'(prescale_s);
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//   Directed bench for timer_counter in its default build (no prescaler).
//   Inputs change 1 ns after a rising edge and outputs are sampled there too.
//   Throughout this file, "E<k>" is the k-th rising edge after the edge that
//   performs the CTRL write (E0).
// -----------------------------------------------------------------------------
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    timer_counter #(.CNT_W(32), .PRESCALE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The write lands on the next rising edge; the task returns 1 ns after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        step(2);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b expected 0", irq); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            vectors++;
            if (d !== 32'd0) begin miscompares++; $display("FAIL rst_read addr%0d: got %h expected 0", a, d); end
        end
        reset = 1'b1;
        step(1);
        // Run a one-shot with PRESET=2 (expires at E4), then hit it with reset while irq is high.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        step(4);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL rst_pre_irq: got %b expected 1", irq); end
        reset = 1'b0;
        #1;
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_async_irq: got %b expected 0", irq); end
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), d);
            vectors++;
            if (d !== 32'd0) begin miscompares++; $display("FAIL rst_async_read addr%0d: got %h expected 0", a, d); end
        end
        #1 reset = 1'b1;
        step(3);
        rd(2'd2, d);
        vectors++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            miscompares++; $display("FAIL rst_release: count %h irq %b expected 0/0", d, irq);
        end
    endtask

    task automatic test_one_shot;
        logic [31:0] d;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step(2);
        // COUNT reads 5,4,3,2,1 after edges E2..E6.
        for (int i = 0; i < 5; i++) begin
            rd(2'd2, d);
            vectors++;
            if (d !== 32'(5 - i) || irq !== 1'b0) begin
                miscompares++; $display("FAIL os_count[%0d]: got %h irq %b expected %h irq 0", i, d, irq, 5 - i);
            end
            step(1);
        end
        rd(2'd2, d);
        vectors++;
        if (irq !== 1'b1 || d !== 32'd0) begin
            miscompares++; $display("FAIL os_expire_E7: irq %b count %h expected 1/0", irq, d);
        end
        step(1);
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h8 || irq !== 1'b1) begin
            miscompares++; $display("FAIL os_en_clear: ctrl %h irq %b expected 8/1", d, irq);
        end
        step(3);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL os_sticky: got %b expected 1", irq); end
        wr(2'd0, 32'h8);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL os_ack: got %b expected 0", irq); end
    endtask

    task automatic test_auto_reload;
        logic exp_irq;
        int   highs;
        // PRESET=3 gives expiries at E5, E10, E15, E20, each a one-cycle pulse.
        highs = 0;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            step(1);
            exp_irq = (k >= 5) && ((k % 5) == 0);
            if (irq === 1'b1) highs++;
            vectors++;
            if (irq !== exp_irq) begin
                miscompares++; $display("FAIL ar_pulse E%0d: got %b expected %b", k, irq, exp_irq);
            end
        end
        vectors++;
        if (highs != 4) begin miscompares++; $display("FAIL ar_pulse_count: got %0d expected 4", highs); end
        wr(2'd0, 32'h0);
        step(3);
        // Same run with IM=0: irq must stay low.
        wr(2'd0, 32'h3);
        highs = 0;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            if (irq !== 1'b0) highs++;
        end
        vectors++;
        if (highs != 0) begin miscompares++; $display("FAIL ar_masked: got %0d irq cycles expected 0", highs); end
        wr(2'd0, 32'h0);
        step(3);
    endtask

    task automatic test_mid_op;
        logic [31:0] d;
        // Clear EN on the edge where COUNT goes 3->2. COUNT then holds at 2.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step(4);
        rd(2'd2, d);
        vectors++;
        if (d !== 32'd3) begin miscompares++; $display("FAIL mid_pre: got %h expected 3", d); end
        wr(2'd0, 32'h8);
        step(5);
        rd(2'd2, d);
        vectors++;
        if (d !== 32'd2 || irq !== 1'b0) begin
            miscompares++; $display("FAIL mid_hold: count %h irq %b expected 2/0", d, irq);
        end
        // Re-enable loads a fresh PRESET. Rewriting PRESET during the run does not affect it.
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);
        step(2);
        rd(2'd2, d);
        vectors++;
        if (d !== 32'd6) begin miscompares++; $display("FAIL mid_reload: got %h expected 6", d); end
        wr(2'd1, 32'd2);
        step(4);
        rd(2'd2, d);
        vectors++;
        if (d !== 32'd1 || irq !== 1'b0) begin
            miscompares++; $display("FAIL mid_preset_rewrite: count %h irq %b expected 1/0", d, irq);
        end
        step(1);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL mid_expire_E8: got %b expected 1", irq); end
        rd(2'd1, d);
        vectors++;
        if (d !== 32'd2) begin miscompares++; $display("FAIL mid_preset_read: got %h expected 2", d); end
        wr(2'd0, 32'h8);
        // PRESET=0 expires at E3.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(2);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL zero_E2: got %b expected 0", irq); end
        step(1);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL zero_E3: got %b expected 1", irq); end
        wr(2'd0, 32'h8);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL zero_ack: got %b expected 0", irq); end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        step(4);
        rd(2'd2, d);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL coll_pre: got %h expected 1", d); end
        // This CTRL write lands on the expiry edge E5. pending must still end up set.
        wr(2'd0, 32'h9);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL coll_irq: got %b expected 1", irq); end
        step(3);
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h8 || irq !== 1'b1) begin
            miscompares++; $display("FAIL coll_after: ctrl %h irq %b expected 8/1", d, irq);
        end
        wr(2'd2, 32'd7);
        rd(2'd2, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL count_wr_ignored: got %h expected 0", d); end
        wr(2'd0, 32'h0);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL coll_ack: got %b expected 0", irq); end
    endtask

    task automatic test_ctrl_fields;
        logic [31:0] d;
        wr(2'd0, 32'hFFFF_FFF8);
        rd(2'd0, d);
        vectors++;
        if (d !== 32'h8) begin miscompares++; $display("FAIL ctrl_upper_zero: got %h expected 8", d); end
        // MODE=10 behaves as one-shot: irq is sticky and EN self-clears.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'hD);
        step(3);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL mode2_expire: got %b expected 1", irq); end
        step(3);
        rd(2'd0, d);
        vectors++;
        if (irq !== 1'b1 || d !== 32'hC) begin
            miscompares++; $display("FAIL mode2_oneshot: irq %b ctrl %h expected 1/c", irq, d);
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_prescale_absent;
        logic [31:0] d;
        wr(2'd3, 32'h2);
        rd(2'd3, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL addr3_read: got %h expected 0", d); end
        rd(2'd1, d);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL addr3_side_effect: preset %h expected 1", d); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mid_op();
        test_collision();
        test_ctrl_fields();
        test_prescale_absent();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
